// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: shift-add multiplier, restoring divider, HI/LO registers.
// Optional divider datapath enabled by defining MDU_DIV_EN.
module mdu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] opr_a_mdu_i,
  input  logic [WIDTH-1:0] opr_b_mdu_i,
  input  logic [2:0]       op_mdu_i,
  input  logic             valid_mdu_i,
  output logic             ready_mdu_o,
  output logic [WIDTH-1:0] hi_mdu_o,
  output logic [WIDTH-1:0] lo_mdu_o,
  output logic             done_mdu_o,
  output logic             dz_mdu_o
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam int unsigned AW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             neg_res_q, neg_res_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   mul_sum;
  logic [AW-1:0]    prod_fix;

  // Magnitudes only for signed ops; unsigned ops keep raw operands.
  assign a_neg    = op_mdu_i[0] & opr_a_mdu_i[WIDTH-1];
  assign b_neg    = op_mdu_i[0] & opr_b_mdu_i[WIDTH-1];
  assign a_abs    = a_neg ? -opr_a_mdu_i : opr_a_mdu_i;
  assign b_abs    = b_neg ? -opr_b_mdu_i : opr_b_mdu_i;
  assign mul_sum  = {1'b0, acc_q[AW-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
  assign prod_fix = neg_res_q ? -acc_q : acc_q;

`ifdef MDU_DIV_EN
  logic             is_div_q, is_div_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_pend_q, dz_pend_d;
  logic             dz_q, dz_d;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff, div_rem;

  // acc holds {remainder, dividend/quotient}; quotient bits enter at the bottom.
  assign div_shift = {acc_q[AW-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;
  assign div_rem   = div_ge ? div_diff : div_shift[WIDTH-1:0];
  assign dz_mdu_o  = dz_q;
`else
  assign dz_mdu_o  = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_res_d = neg_res_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    ready_d   = ready_q;
`ifdef MDU_DIV_EN
    is_div_d  = is_div_q;
    neg_rem_d = neg_rem_q;
    dz_pend_d = dz_pend_q;
    dz_d      = dz_q;
`endif
    case (state_q)
      IDLE: begin
        if (valid_mdu_i) begin
          if (op_mdu_i[2:1] == 2'b00) begin
            opnd_d    = a_abs;
            acc_d     = {{WIDTH{1'b0}}, b_abs};
            neg_res_d = a_neg ^ b_neg;
            cnt_d     = CW'(WIDTH);
            ready_d   = 1'b0;
            state_d   = CALC;
`ifdef MDU_DIV_EN
            is_div_d  = 1'b0;
`endif
          end
`ifdef MDU_DIV_EN
          else if (op_mdu_i[2:1] == 2'b01) begin
            opnd_d    = b_abs;
            acc_d     = {{WIDTH{1'b0}}, a_abs};
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            dz_pend_d = (opr_b_mdu_i == {WIDTH{1'b0}});
            is_div_d  = 1'b1;
            cnt_d     = CW'(WIDTH);
            ready_d   = 1'b0;
            state_d   = CALC;
          end
`endif
          else if (op_mdu_i == 3'b100) begin
            hi_d   = opr_a_mdu_i;
            done_d = 1'b1;
          end
          else if (op_mdu_i == 3'b101) begin
            lo_d   = opr_a_mdu_i;
            done_d = 1'b1;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q - CW'(1);
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef MDU_DIV_EN
        if (is_div_q) acc_d = {div_rem, acc_q[WIDTH-2:0], div_ge};
`endif
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        // Sign correction and result write-back.
        hi_d = prod_fix[AW-1:WIDTH];
        lo_d = prod_fix[WIDTH-1:0];
`ifdef MDU_DIV_EN
        if (is_div_q) begin
          lo_d = dz_pend_q ? {WIDTH{1'b1}}
               : (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
          hi_d = neg_rem_q ? -acc_q[AW-1:WIDTH] : acc_q[AW-1:WIDTH];
          dz_d = dz_pend_q;
        end
`endif
        done_d  = 1'b1;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_res_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
`ifdef MDU_DIV_EN
      is_div_q  <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_pend_q <= 1'b0;
      dz_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_res_q <= neg_res_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
`ifdef MDU_DIV_EN
      is_div_q  <= is_div_d;
      neg_rem_q <= neg_rem_d;
      dz_pend_q <= dz_pend_d;
      dz_q      <= dz_d;
`endif
    end
  end

  assign ready_mdu_o = ready_q;
  assign hi_mdu_o    = hi_q;
  assign lo_mdu_o    = lo_q;
  assign done_mdu_o  = done_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter (WIDTH=32) against an arithmetic reference model.
module tb_mdu_iter;
  localparam int unsigned W = 32;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] opr_a, opr_b;
  logic [2:0]   op;
  logic         valid;
  logic         ready;
  logic [W-1:0] hi, lo;
  logic         done;
  logic         dz;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;
  logic         exp_dz = 1'b0;

  mdu_iter #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .opr_a_mdu_i (opr_a),
    .opr_b_mdu_i (opr_b),
    .op_mdu_i    (op),
    .valid_mdu_i (valid),
    .ready_mdu_o (ready),
    .hi_mdu_o    (hi),
    .lo_mdu_o    (lo),
    .done_mdu_o  (done),
    .dz_mdu_o    (dz)
  );

  always #5 clk = ~clk;

  // Reference: updates expected HI/LO/dz; returns 1 if the op produces a done pulse.
  function automatic bit model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] up;
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: begin up = {32'b0, a} * {32'b0, b}; exp_hi = up[63:32]; exp_lo = up[31:0]; return 1'b1; end
      3'd1: begin up = 64'(sa * sb); exp_hi = up[63:32]; exp_lo = up[31:0]; return 1'b1; end
      3'd2, 3'd3: begin
        if (!DIV_EN) return 1'b0;
        if (b == 0) begin
          exp_lo = '1; exp_hi = a; exp_dz = 1'b1;
        end else if (o == 3'd2) begin
          exp_lo = a / b; exp_hi = a % b; exp_dz = 1'b0;
        end else begin
          q = sa / sb; r = sa % sb;
          exp_lo = q[31:0]; exp_hi = r[31:0]; exp_dz = 1'b0;
        end
        return 1'b1;
      end
      3'd4: begin exp_hi = a; return 1'b1; end
      3'd5: begin exp_lo = a; return 1'b1; end
      default: return 1'b0;
    endcase
  endfunction

  // Issue one op from idle and wait (bounded) for done; reports latency and whether ready dipped correctly.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output bit ready_low_ok);
    @(negedge clk);
    op = o; opr_a = a; opr_b = b; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    lat = 1;
    ready_low_ok = 1'b1;
    while (!done && lat < 100) begin
      if (ready) ready_low_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; valid = 1'b0; op = '0; opr_a = '0; opr_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (hi !== '0 || lo !== '0 || done !== 1'b0 || dz !== 1'b0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: hi=%h lo=%h done=%b dz=%b ready=%b, required 0/0/0/0/1", hi, lo, done, dz, ready);
    end
  endtask

  task automatic test_mul;
    logic [2:0]   ops [3] = '{3'd0, 3'd1, 3'd1};
    logic [W-1:0] as  [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000};
    logic [W-1:0] bs  [3] = '{32'hFFFF_FFFF, 32'd7,         32'h8000_0000};
    int lat;
    bit rok;
    for (int i = 0; i < 11; i++) begin
      logic [2:0] o;
      logic [W-1:0] a, b;
      if (i < 3) begin o = ops[i]; a = as[i]; b = bs[i]; end
      else begin o = 3'($urandom_range(0, 1)); a = $urandom; b = $urandom; end
      void'(model(o, a, b));
      run_op(o, a, b, lat, rok);
      n_checks++;
      if (lat !== W + 2 || !rok) begin
        n_fail++;
        $display("FAIL mul_latency[%0d]: latency=%0d ready_low=%b, required %0d/1", i, lat, rok, W + 2);
      end
      n_checks++;
      if (hi !== exp_hi || lo !== exp_lo || dz !== exp_dz) begin
        n_fail++;
        $display("FAIL mul_result[%0d] op=%0d a=%h b=%h: hi=%h lo=%h dz=%b, required %h %h %b",
                 i, o, a, b, hi, lo, dz, exp_hi, exp_lo, exp_dz);
      end
    end
  endtask

  task automatic test_div;
`ifdef MDU_DIV_EN
    logic [2:0]   ops [6] = '{3'd2, 3'd3, 3'd3, 3'd2, 3'd0, 3'd3};
    logic [W-1:0] as  [6] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'd5, 32'd3, 32'h8000_0000};
    logic [W-1:0] bs  [6] = '{32'd7,   32'd2, 32'hFFFF_FFFE, 32'd0, 32'd4, 32'hFFFF_FFFF};
    int lat;
    bit rok;
    for (int i = 0; i < 14; i++) begin
      logic [2:0] o;
      logic [W-1:0] a, b;
      if (i < 6) begin o = ops[i]; a = as[i]; b = bs[i]; end
      else begin
        o = 3'($urandom_range(2, 3)); a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? '0 : (($urandom_range(0, 1) == 1) ? W'($urandom_range(1, 300)) : W'($urandom));
      end
      void'(model(o, a, b));
      run_op(o, a, b, lat, rok);
      n_checks++;
      if (lat !== W + 2 || !rok) begin
        n_fail++;
        $display("FAIL div_latency[%0d]: latency=%0d ready_low=%b, required %0d/1", i, lat, rok, W + 2);
      end
      n_checks++;
      if (hi !== exp_hi || lo !== exp_lo || dz !== exp_dz) begin
        n_fail++;
        $display("FAIL div_result[%0d] op=%0d a=%h b=%h: hi=%h lo=%h dz=%b, required %h %h %b",
                 i, o, a, b, hi, lo, dz, exp_hi, exp_lo, exp_dz);
      end
    end
`else
    bit got_done = 1'b0;
    bit ready_drop = 1'b0;
    @(negedge clk);
    op = 3'd2; opr_a = 32'd100; opr_b = 32'd7; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    for (int c = 0; c < W + 6; c++) begin
      if (done) got_done = 1'b1;
      if (!ready) ready_drop = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (got_done || ready_drop || hi !== exp_hi || lo !== exp_lo || dz !== 1'b0) begin
      n_fail++;
      $display("FAIL divu_disabled: done_seen=%b ready_drop=%b hi=%h lo=%h dz=%b, required 0/0/%h/%h/0",
               got_done, ready_drop, hi, lo, dz, exp_hi, exp_lo);
    end
`endif
  endtask

  task automatic test_mt;
    @(negedge clk);
    op = 3'd4; opr_a = 32'h1234; opr_b = $urandom; valid = 1'b1;
    void'(model(3'd4, 32'h1234, '0));
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || hi !== exp_hi || lo !== exp_lo || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mthi: done=%b hi=%h lo=%h ready=%b, required 1/%h/%h/1", done, hi, lo, ready, exp_hi, exp_lo);
    end
    op = 3'd5; opr_a = 32'h5678;
    void'(model(3'd5, 32'h5678, '0));
    @(negedge clk);
    valid = 1'b0;
    n_checks++;
    if (done !== 1'b1 || hi !== exp_hi || lo !== exp_lo || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mtlo: done=%b hi=%h lo=%h ready=%b, required 1/%h/%h/1", done, hi, lo, ready, exp_hi, exp_lo);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL mt_done_pulse: done=%b, required 0", done);
    end
  endtask

  task automatic test_undef;
    bit got_done = 1'b0;
    bit ready_drop = 1'b0;
    @(negedge clk);
    op = 3'd6; opr_a = $urandom; opr_b = $urandom; valid = 1'b1;
    @(negedge clk);
    op = 3'd7;
    @(negedge clk);
    valid = 1'b0;
    for (int c = 0; c < W + 6; c++) begin
      if (done) got_done = 1'b1;
      if (!ready) ready_drop = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (got_done || ready_drop || hi !== exp_hi || lo !== exp_lo || dz !== exp_dz) begin
      n_fail++;
      $display("FAIL undef_op: done_seen=%b ready_drop=%b hi=%h lo=%h, required 0/0/%h/%h",
               got_done, ready_drop, hi, lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] xa, xb, ya, yb;
    int lat;
    xa = $urandom; xb = $urandom; ya = $urandom; yb = $urandom;
    @(negedge clk);
    op = 3'd1; opr_a = xa; opr_b = xb; valid = 1'b1;
    @(negedge clk);
    op = 3'd0; opr_a = ya; opr_b = yb;
    lat = 1;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    void'(model(3'd1, xa, xb));
    n_checks++;
    if (lat !== W + 2 || hi !== exp_hi || lo !== exp_lo) begin
      n_fail++;
      $display("FAIL b2b_first: latency=%0d hi=%h lo=%h, required %0d %h %h", lat, hi, lo, W + 2, exp_hi, exp_lo);
    end
    @(negedge clk);
    valid = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    void'(model(3'd0, ya, yb));
    n_checks++;
    if (lat !== W + 2 || hi !== exp_hi || lo !== exp_lo) begin
      n_fail++;
      $display("FAIL b2b_second: latency=%0d hi=%h lo=%h, required %0d %h %h", lat, hi, lo, W + 2, exp_hi, exp_lo);
    end
  endtask

  task automatic test_rst_abort;
    int lat;
    bit rok;
    bit got_done = 1'b0;
    run_op(3'd4, 32'hAAAA_0001, '0, lat, rok);
    @(negedge clk);
    op = 3'd1; opr_a = $urandom; opr_b = $urandom; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
    n_checks++;
    if (hi !== '0 || lo !== '0 || ready !== 1'b1 || done !== 1'b0 || dz !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_abort: hi=%h lo=%h ready=%b done=%b dz=%b, required 0/0/1/0/0", hi, lo, ready, done, dz);
    end
    for (int c = 0; c < W + 6; c++) begin
      if (done) got_done = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (got_done || hi !== '0 || lo !== '0) begin
      n_fail++;
      $display("FAIL rst_no_done: done_seen=%b hi=%h lo=%h, required 0/0/0", got_done, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_mt();
    test_undef();
    test_back_to_back();
    test_rst_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative multiply/divide unit for the MIPS datapath, the sequential companion to the single-cycle ALU. Executes MULT/MULTU/DIV/DIVU over WIDTH cycles with a shift-add multiplier and restoring divider, holds the HI/LO result registers, and supports MTHI/MTLO writes. The decode stage issues operations through a valid/ready handshake and stalls on `ready_mdu_o` until the unit is free.

## Interface
- `WIDTH`, default 32: operand and HI/LO width; legal range is WIDTH >= 2.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `opr_a_mdu_i`  in  WIDTH  operand A (multiplicand / dividend / MTHI-MTLO data).
- `opr_b_mdu_i`  in  WIDTH  operand B (multiplier / divisor).
- `op_mdu_i`  in  3  operation code:
  - 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO.
  - 110 and 111 are undefined.
- `valid_mdu_i`  in  1  request valid.
- `ready_mdu_o`  out  1  unit can accept; high only in IDLE.
- `hi_mdu_o`  out  WIDTH  HI register (product upper half / remainder).
- `lo_mdu_o`  out  WIDTH  LO register (product lower half / quotient).
- `done_mdu_o`  out  1  one-cycle pulse: HI/LO just updated.
- `dz_mdu_o`  out  1  registered divide-by-zero flag of the last divide; holds until the next divide completes.

## Operation
- Reset values: `hi_mdu_o`=0, `lo_mdu_o`=0, `done_mdu_o`=0, `dz_mdu_o`=0, `ready_mdu_o`=1. State returns to IDLE.
- States:
  - IDLE: transitions to CALC on accept of a mul/div op.
  - CALC: runs for WIDTH cycles, counted by a down-counter of width $clog2(WIDTH)+1, then goes to FIX.
  - FIX: lasts 1 cycle, then returns to IDLE.
- Accept: `valid_mdu_i` && `ready_mdu_o` at a rising edge. When not ready, `valid_mdu_i` is ignored and operands are not sampled.
- At accept, the unit latches |A|, |B|, the result sign (A^B) and the remainder sign (A). Unsigned ops take the raw operands with both signs 0.
- Multiply: one add-and-shift per CALC cycle over a 2*WIDTH accumulator. FIX negates the 2*WIDTH product if the sign bit is set. Result is written as HI = upper WIDTH bits, LO = lower WIDTH bits.
- Divide: one restoring subtract per CALC cycle. FIX negates the quotient when the result sign is set and negates the remainder when the remainder sign is set. Result is written as LO = quotient, HI = remainder.
- Divide by zero (B == 0): LO = all ones, HI = raw opr_a, `dz_mdu_o`=1. Latency is unchanged.
- Signed overflow (most-negative / -1): LO = most-negative, HI = 0. This is the natural wrap, with no special case.
- MTHI/MTLO: write HI or LO at the accept edge; `done_mdu_o` pulses in the next cycle; state stays IDLE; the other register is untouched.
- Undefined ops: accepted and ignored; no register change and no done pulse.
- HI/LO change only at FIX completion or MTHI/MTLO accept. Outputs are stable during CALC.
- `rst` asserted in any state aborts the operation, applies the reset values, and produces no done pulse.

## Timing
- Mul/div accepted at edge t0:
  - CALC occupies cycles t0+1 .. t0+WIDTH.
  - FIX is cycle t0+WIDTH+1; HI/LO are registered at its end.
  - `done_mdu_o`=1 and `ready_mdu_o`=1 in cycle t0+WIDTH+2.
  - Total latency is WIDTH+2 cycles.
- A new op may be accepted in the same cycle `done_mdu_o` is high (back-to-back, no bubble).
- MTHI/MTLO: latency 1 cycle; `ready_mdu_o` stays high throughout.

## Configuration
- `MDU_DIV_EN` defined: the divider datapath, the DIVU/DIV opcodes and `dz_mdu_o` are implemented as above.
- Not defined: the divider is omitted; 010/011 behave as undefined ops (accepted, ignored); `dz_mdu_o` is tied 0. Multiply and MTHI/MTLO behaviour and timing are unchanged.

## Test plan
- MULTU 0xFFFFFFFF x 0xFFFFFFFF (WIDTH=32) -> HI=0xFFFFFFFE, LO=0x00000001, done exactly 34 cycles after accept, ready low for cycles 1..33.
- MULT -3 x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
- DIVU 100/7 -> LO=14, HI=2. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 7/-2 -> LO=0xFFFFFFFD, HI=1.
- DIVU 5/0 -> LO=0xFFFFFFFF, HI=5, dz=1. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0, dz=0.
- Hold `valid_mdu_i` with new operands throughout a MULT -> ignored until the done cycle, then accepted in that cycle. Assert rst at CALC cycle 10 -> HI/LO=0, ready=1 next cycle, no done pulse.
- MTHI 0x1234 then MTLO 0x5678 on consecutive cycles -> HI=0x1234, then LO=0x5678, each with a done pulse. Op 110 -> no change, no done. Without `MDU_DIV_EN`, DIVU 100/7 -> HI/LO unchanged, no done.
